round_pipe: RTL and testbench
=============================

// Module: round_pipe
// PURPOSE
//   Pipelined, handshaked successor to the combinational rounding stage of the FPU datapath.
//   Takes a normalised significand (hidden bit at MSB) and exponent from the normaliser.
//   Applies all five RISC-V rounding modes and raises inexact/overflow flags.
//   Accepts one operand per cycle with 2-cycle latency; valid/ready on both sides.
// PARAMETERS
//   SIG_BITS  32  input significand width; MSB = hidden bit
//   FRA_BITS  23  stored fraction bits; kept field = sig[SIG_BITS-1 -: FRA_BITS+1]
//   EXP_BITS   8  biased exponent width; all-ones = Inf/NaN
//   FRM_BITS   3  rounding-mode field width
// PORTS
//   clk        in   1          clock
//   rst_n      in   1          async active-low reset
//   in_valid   in   1          operand valid
//   in_ready   out  1          block can accept operand this cycle
//   in_sig     in   SIG_BITS   normalised significand
//   in_exp     in   EXP_BITS   biased exponent
//   in_sign    in   1          sign
//   in_frm     in   FRM_BITS   000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM
//   flush      in   1          sync clear of all in-flight operands
//   out_valid  out  1          result valid
//   out_ready  in   1          consumer accepts result
//   out_sig    out  SIG_BITS   rounded significand; bits below kept field are 0
//   out_exp    out  EXP_BITS   adjusted exponent
//   out_sign   out  1          sign, passed through
//   out_nx     out  1          inexact flag
//   out_of     out  1          overflow flag
// BEHAVIOUR
// - Reset: single clock clk; rst_n asynchronous active-low.
//   - While rst_n=0: all stage valids and all out_* registers are 0, and in_ready=0.
//   - After rst_n=1, in_ready=1 from the next edge.
// - Bit fields: K = sig[SIG_BITS-1 -: FRA_BITS+1].
//   - L = K[0].
//   - R = sig[SIG_BITS-FRA_BITS-2].
//   - S = OR of all lower bits.
// - Increment inc:
//   - RNE: R&(S|L).
//   - RTZ: 0.
//   - RDN: sign&(R|S).
//   - RUP: !sign&(R|S).
//   - RMM: R.
//   - Codes 101..111: inc=0 (treated as RTZ).
// - Stage 1 (register S1): latches K, exp, sign, inc, nx=R|S.
//   - Also latches special = (exp == all-ones).
// - Stage 2 (register S2 = outputs): computes {c,K'} = K + inc, an (FRA_BITS+2)-bit sum.
//   - c=1: K' = 1000..0 and exp' = exp+1.
//   - c=0: K' and exp unchanged.
// - Overflow: c=1 and exp+1 == all-ones gives out_exp = all-ones, out_sig = 1000..0 (Inf).
//   - out_of=1, out_nx=1.
//   - RTZ never increments, so it never overflows.
// - Special (exp all-ones on input): sig/exp/sign pass through unrounded; out_nx=out_of=0.
// - Handshake:
//   - Transfer occurs when valid&ready are both high on a rising edge.
//   - S2 loads when !out_valid | out_ready.
//   - S1 loads when S1 is empty or S1 advances.
//   - in_ready = !s1_valid | s2_load (combinational).
// - Latency and throughput: 2 cycles input-to-output; throughput 1/cycle with out_ready=1.
//   - Two entries are held under backpressure.
// - out_* hold stable while out_valid=1 & out_ready=0. No drop, duplication or reordering.
// - flush=1: clears s1_valid and out_valid next edge; flush wins over a simultaneous input transfer.
// - Width rules: exponent add is modulo 2^EXP_BITS; overflow is detected before wrap.
// TESTING (SIG_BITS=32, FRA_BITS=23, EXP_BITS=8)
//   1. RNE ties, exp=0x10:
//      - sig=0x80000080 -> out_sig=0x80000000, nx=1.
//      - sig=0x80000180 -> out_sig=0x80000200, nx=1.
//   2. Mantissa carry: sig=0xFFFFFF80, exp=0x10, RNE -> out_sig=0x80000000, out_exp=0x11, of=0.
//   3. Overflow: sig=0xFFFFFFFF, exp=0xFE.
//      - RNE -> out_exp=0xFF, out_sig=0x80000000, of=1, nx=1.
//      - RTZ -> out_sig=0xFFFFFF00, out_exp=0xFE, of=0, nx=1.
//   4. Directed modes, sig=0x80000040 (R=0, S=1):
//      - RDN: sign=1 -> 0x80000100; sign=0 -> 0x80000000.
//      - RUP: mirror of RDN.
//      - RMM -> 0x80000000.
//      - frm=101 -> 0x80000000.
//   5. Backpressure: 4 back-to-back inputs with out_ready=0 for 3 cycles.
//      - in_ready drops after 2 accepted; out_* stable.
//      - After release, all 4 results emerge in order.
//   6. Reset/flush with both stages full:
//      - rst_n low -> out_valid=0 immediately (async).
//      - flush -> out_valid=0 next edge; the input offered that cycle is discarded.

Source files
------------

// File: rtl/round_pipe.sv
// Two-stage handshaked rounding pipeline: stage 1 decides the increment,
// stage 2 applies it, handles mantissa carry, overflow and special operands.
module round_pipe #(
  parameter int unsigned SIG_BITS = 32,
  parameter int unsigned FRA_BITS = 23,
  parameter int unsigned EXP_BITS = 8,
  parameter int unsigned FRM_BITS = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SIG_BITS-1:0] in_sig,
  input  logic [EXP_BITS-1:0] in_exp,
  input  logic                in_sign,
  input  logic [FRM_BITS-1:0] in_frm,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SIG_BITS-1:0] out_sig,
  output logic [EXP_BITS-1:0] out_exp,
  output logic                out_sign,
  output logic                out_nx,
  output logic                out_of
);

  localparam int unsigned KW = FRA_BITS + 1;
  localparam int unsigned LW = SIG_BITS - KW;

  localparam logic [FRM_BITS-1:0] FRM_RNE = FRM_BITS'(0);
  localparam logic [FRM_BITS-1:0] FRM_RDN = FRM_BITS'(2);
  localparam logic [FRM_BITS-1:0] FRM_RUP = FRM_BITS'(3);
  localparam logic [FRM_BITS-1:0] FRM_RMM = FRM_BITS'(4);

  logic                rdy_en;
  logic                s1_valid;
  logic                s1_load;
  logic                s2_load;
  logic                in_fire;
  logic [KW-1:0]       s1_k;
  logic [EXP_BITS-1:0] s1_exp;
  logic                s1_sign;
  logic                s1_inc;
  logic                s1_nx;
  logic                s1_special;

  logic [KW-1:0]       k_in;
  logic                l_in;
  logic                r_in;
  logic                s_in;
  logic                inc_c;

  logic [KW:0]         sum_c;
  logic [EXP_BITS-1:0] exp_inc_c;
  logic [KW-1:0]       nxt_k_c;
  logic [EXP_BITS-1:0] nxt_exp_c;
  logic                nxt_nx_c;
  logic                nxt_of_c;

  assign k_in = in_sig[SIG_BITS-1 -: KW];
  assign l_in = k_in[0];
  assign r_in = in_sig[LW-1];
  assign s_in = |in_sig[LW-2:0];

  // Increment decision per rounding mode; reserved codes behave as RTZ
  always_comb begin
    inc_c = 1'b0;
    case (in_frm)
      FRM_RNE: inc_c = r_in & (s_in | l_in);
      FRM_RDN: inc_c = in_sign & (r_in | s_in);
      FRM_RUP: inc_c = !in_sign & (r_in | s_in);
      FRM_RMM: inc_c = r_in;
      default: inc_c = 1'b0;
    endcase
  end

  assign s2_load  = !out_valid | out_ready;
  assign s1_load  = !s1_valid | s2_load;
  assign in_ready = rdy_en & s1_load;
  assign in_fire  = in_valid & in_ready & !flush;

  // in_ready stays low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_k       <= '0;
      s1_exp     <= '0;
      s1_sign    <= 1'b0;
      s1_inc     <= 1'b0;
      s1_nx      <= 1'b0;
      s1_special <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= in_fire;
      if (in_fire) begin
        s1_k       <= k_in;
        s1_exp     <= in_exp;
        s1_sign    <= in_sign;
        s1_inc     <= inc_c;
        s1_nx      <= r_in | s_in;
        s1_special <= (in_exp == '1);
      end
    end
  end

  // Apply increment; a carry out renormalises and may overflow to Inf
  always_comb begin
    sum_c     = {1'b0, s1_k} + (KW+1)'(s1_inc);
    exp_inc_c = s1_exp + EXP_BITS'(1);
    nxt_k_c   = sum_c[KW-1:0];
    nxt_exp_c = s1_exp;
    nxt_nx_c  = s1_nx;
    nxt_of_c  = 1'b0;
    if (s1_special) begin
      nxt_k_c  = s1_k;
      nxt_nx_c = 1'b0;
    end else if (sum_c[KW]) begin
      nxt_k_c   = {1'b1, {(KW-1){1'b0}}};
      nxt_exp_c = exp_inc_c;
      if (exp_inc_c == '1) begin
        nxt_of_c = 1'b1;
        nxt_nx_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sig   <= '0;
      out_exp   <= '0;
      out_sign  <= 1'b0;
      out_nx    <= 1'b0;
      out_of    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_sig  <= {nxt_k_c, {LW{1'b0}}};
        out_exp  <= nxt_exp_c;
        out_sign <= s1_sign;
        out_nx   <= nxt_nx_c;
        out_of   <= nxt_of_c;
      end
    end
  end

endmodule

// File: tb/tb_round_pipe.sv
// Self-checking bench for round_pipe: directed literal cases plus randomized
// traffic against an arithmetic rounding model and an in-order scoreboard.
module tb_round_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_sig;
  logic [7:0]  in_exp;
  logic        in_sign;
  logic [2:0]  in_frm;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sig;
  logic [7:0]  out_exp;
  logic        out_sign;
  logic        out_nx;
  logic        out_of;

  int errors = 0;
  int checks = 0;
  int n_out  = 0;

  logic [42:0] sb[$];
  logic [42:0] held;
  bit          held_v = 0;

  round_pipe #(.SIG_BITS(32), .FRA_BITS(23), .EXP_BITS(8), .FRM_BITS(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sig(in_sig), .in_exp(in_exp),
    .in_sign(in_sign), .in_frm(in_frm), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_sig(out_sig), .out_exp(out_exp),
    .out_sign(out_sign), .out_nx(out_nx), .out_of(out_of)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result as {sig, exp, sign, nx, of}, derived from the remainder below the kept field
  function automatic logic [42:0] model(input logic [31:0] sig, input logic [7:0] e,
                                        input logic sgn, input logic [2:0] frm);
    int unsigned k, rem, oe;
    bit up, nx, of;
    k   = sig >> 8;
    rem = sig & 32'hFF;
    nx  = (rem != 0);
    of  = 0;
    oe  = e;
    case (frm)
      3'd0:    up = (rem > 128) || (rem == 128 && (k % 2) == 1);
      3'd2:    up = sgn && nx;
      3'd3:    up = !sgn && nx;
      3'd4:    up = (rem >= 128);
      default: up = 0;
    endcase
    if (e == 8'hFF) begin
      up = 0;
      nx = 0;
    end
    k = k + (up ? 1 : 0);
    if (k == (1 << 24)) begin
      k  = 1 << 23;
      oe = e + 1;
      of = (oe == 255);
    end
    return {32'(k << 8), 8'(oe), sgn, nx, of};
  endfunction

  // Scoreboard and hold-stability monitor, sampled mid-cycle
  always @(negedge clk) begin
    logic [42:0] cur, e;
    cur = {out_sig, out_exp, out_sign, out_nx, out_of};
    if (!rst_n) begin
      sb.delete();
      held_v = 0;
    end else begin
      if (held_v) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'(cur), 64'(held));
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got %h expected none (t=%0t)", cur, $time);
        end else begin
          e = sb.pop_front();
          chk("out_vs_model", 64'(cur), 64'(e));
        end
      end
      if (in_valid && in_ready && !flush)
        sb.push_back(model(in_sig, in_exp, in_sign, in_frm));
      if (flush) sb.delete();
      held_v = out_valid && !out_ready && !flush;
      held   = cur;
    end
  end

  task automatic drive(input bit v, input logic [31:0] s, input logic [7:0] e, input bit sg,
                       input logic [2:0] f, input bit ordy, input bit fl);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_sig    = s;
    in_exp    = e;
    in_sign   = sg;
    in_frm    = f;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 32'h0, 8'h0, 0, 3'd0, 1, 0);
  endtask

  // One operand through an empty pipe; checks latency and literal result
  task automatic run_one(input string name, input logic [31:0] s, input logic [7:0] e,
                         input bit sg, input logic [2:0] f, input logic [31:0] xs,
                         input logic [7:0] xe, input bit xnx, input bit xof);
    int lat;
    drive(1, s, e, sg, f, 1, 0);
    @(negedge clk);
    chk({name, "_accept"}, 64'(in_ready), 64'd1);
    drive(0, 32'h0, 8'h0, 0, 3'd0, 1, 0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 8);
    chk({name, "_latency"}, 64'(lat), 64'd2);
    chk({name, "_result"}, {out_sig, out_exp, out_sign, out_nx, out_of}, {xs, xe, sg, xnx, xof});
  endtask

  initial begin
    int idx, base, guard;
    bit cur_v, acc;
    logic [31:0] rs, rr;
    logic [7:0]  re;

    rst_n = 0; in_valid = 0; in_sig = 0; in_exp = 0; in_sign = 0; in_frm = 0;
    flush = 0; out_ready = 0;
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    chk("reset_out_sig", 64'(out_sig), 64'd0);
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1;
    #1 chk("release_in_ready_before_edge", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 chk("release_in_ready_after_edge", 64'(in_ready), 64'd1);

    // Model pinned against hand-computed values
    chk("model_rne_tie_even", 64'(model(32'h80000080, 8'h10, 0, 3'd0)),
        64'({32'h80000000, 8'h10, 1'b0, 1'b1, 1'b0}));
    chk("model_overflow", 64'(model(32'hFFFFFFFF, 8'hFE, 1, 3'd0)),
        64'({32'h80000000, 8'hFF, 1'b1, 1'b1, 1'b1}));

    run_one("rne_tie_even", 32'h80000080, 8'h10, 0, 3'd0, 32'h80000000, 8'h10, 1, 0);
    run_one("rne_tie_odd",  32'h80000180, 8'h10, 0, 3'd0, 32'h80000200, 8'h10, 1, 0);
    run_one("carry",        32'hFFFFFF80, 8'h10, 0, 3'd0, 32'h80000000, 8'h11, 1, 0);
    run_one("ovf_rne",      32'hFFFFFFFF, 8'hFE, 0, 3'd0, 32'h80000000, 8'hFF, 1, 1);
    run_one("ovf_rtz",      32'hFFFFFFFF, 8'hFE, 0, 3'd1, 32'hFFFFFF00, 8'hFE, 1, 0);
    run_one("rdn_neg",      32'h80000040, 8'h10, 1, 3'd2, 32'h80000100, 8'h10, 1, 0);
    run_one("rdn_pos",      32'h80000040, 8'h10, 0, 3'd2, 32'h80000000, 8'h10, 1, 0);
    run_one("rup_pos",      32'h80000040, 8'h10, 0, 3'd3, 32'h80000100, 8'h10, 1, 0);
    run_one("rup_neg",      32'h80000040, 8'h10, 1, 3'd3, 32'h80000000, 8'h10, 1, 0);
    run_one("rmm",          32'h80000040, 8'h10, 0, 3'd4, 32'h80000000, 8'h10, 1, 0);
    run_one("frm_101",      32'h80000040, 8'h10, 0, 3'd5, 32'h80000000, 8'h10, 1, 0);
    run_one("special",      32'hC00001C0, 8'hFF, 0, 3'd3, 32'hC0000100, 8'hFF, 0, 0);
    idle(2);

    // Backpressure: only two entries fit while the consumer stalls
    idx = 0;
    base = n_out;
    for (int c = 0; c < 5; c++) begin
      drive(idx < 4, 32'h80000040 | (32'(idx) << 9), 8'h20, 0, 3'd3, 0, 0);
      @(negedge clk);
      if (in_valid && in_ready) idx++;
    end
    chk("bp_accepted", 64'(idx), 64'd2);
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    guard = 0;
    while (idx < 4 && guard < 20) begin
      drive(1, 32'h80000040 | (32'(idx) << 9), 8'h20, 0, 3'd3, 1, 0);
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      guard++;
    end
    idle(5);
    chk("bp_all_out", 64'(n_out - base), 64'd4);
    chk("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Flush with both stages full; the operand offered alongside is dropped
    drive(1, 32'h80000100, 8'h30, 0, 3'd0, 0, 0);
    drive(1, 32'h80000200, 8'h30, 0, 3'd0, 0, 0);
    drive(1, 32'h80000300, 8'h30, 0, 3'd0, 0, 1);
    base = n_out;
    drive(0, 32'h0, 8'h0, 0, 3'd0, 1, 0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    idle(4);
    chk("flush_nothing_out", 64'(n_out - base), 64'd0);

    // Async reset with both stages full
    drive(1, 32'h80000100, 8'h30, 0, 3'd0, 0, 0);
    drive(1, 32'h80000200, 8'h30, 0, 3'd0, 0, 0);
    drive(0, 32'h0, 8'h0, 0, 3'd0, 0, 0);
    #2 rst_n = 0;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_in_ready", 64'(in_ready), 64'd0);
    chk("async_rst_out_sig", 64'(out_sig), 64'd0);
    @(posedge clk);
    #2 rst_n = 1;
    @(posedge clk);
    #1 chk("rerelease_in_ready", 64'(in_ready), 64'd1);
    idle(2);

    // Randomized traffic with stalls and occasional flushes
    cur_v = 0; acc = 0; rs = 0; re = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!cur_v || acc) begin
        rr = $urandom;
        rs = {1'b1, rr[30:0]};
        case ($urandom_range(0, 4))
          0: rs[7:0] = 8'h80;
          1: rs[7:0] = 8'h00;
          2: rs[31:8] = 24'hFFFFFF;
          default: ;
        endcase
        case ($urandom_range(0, 5))
          0: re = 8'hFE;
          1: re = 8'hFF;
          2: re = 8'h00;
          default: begin rr = $urandom; re = rr[7:0]; end
        endcase
        rr = $urandom;
      end
      cur_v = ($urandom_range(0, 3) != 0);
      drive(cur_v, rs, re, rr[8], 3'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
      @(negedge clk);
      acc = in_valid && (in_ready || flush);
    end
    idle(6);
    chk("final_sb_empty", 64'(sb.size()), 64'd0);
    chk("final_out_valid", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
